// File: rtl/axe_multicut_bundle.sv
// axe_multicut_bundle: multi-channel valid/ready pipeline cut with occupancy reporting and isolate/drain
module axe_multicut_bundle #(
  parameter int NumChannels = 5,
  parameter int DataWidth = 64,
  parameter int NumCuts = 1,
  parameter int CutMode = 0,
  parameter int OccWidth = (NumCuts == 0) ? 1 : $clog2(2 * NumCuts + 1)
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic                               i_isolate,
  output logic                               o_isolated,
  input  logic [NumChannels*DataWidth-1:0]   i_s_data,
  input  logic [NumChannels-1:0]             i_s_valid,
  output logic [NumChannels-1:0]             o_s_ready,
  output logic [NumChannels*DataWidth-1:0]   o_m_data,
  output logic [NumChannels-1:0]             o_m_valid,
  input  logic [NumChannels-1:0]             i_m_ready,
  output logic [NumChannels*OccWidth-1:0]    o_occupancy
);
  logic [NumChannels-1:0] empty;
  logic isolated_q, isolated_d;
  for (genvar c = 0; c < NumChannels; c++) begin : g_ch
    logic [NumCuts:0] v, r;
    logic [DataWidth-1:0] d [NumCuts+1];
    logic [OccWidth-1:0] occ_q, occ_d;
    assign v[0] = i_s_valid[c] & ~i_isolate;
    assign d[0] = i_s_data[c*DataWidth +: DataWidth];
    assign r[NumCuts] = i_m_ready[c];
    for (genvar k = 0; k < NumCuts; k++) begin : g_cut
      if (CutMode == 0) begin : g_full
        logic a_full_q, a_full_d, b_full_q, b_full_d, push, pop;
        logic [DataWidth-1:0] a_data_q, a_data_d, b_data_q, b_data_d;
        always_comb begin
          push = v[k] & ~b_full_q;
          pop = a_full_q & r[k+1];
          a_full_d = b_full_q | push | (a_full_q & ~pop);
          b_full_d = b_full_q ? ~pop : push & a_full_q & ~pop;
          a_data_d = (b_full_q & pop) ? b_data_q : (push & (pop | ~a_full_q)) ? d[k] : a_data_q;
          b_data_d = (~b_full_q & push & a_full_q & ~pop) ? d[k] : b_data_q;
        end
        always_ff @(posedge i_clk) begin
          a_full_q <= i_rst ? 1'b0 : a_full_d;
          b_full_q <= i_rst ? 1'b0 : b_full_d;
          a_data_q <= a_data_d;
          b_data_q <= b_data_d;
        end
        assign r[k] = ~b_full_q;
        assign v[k+1] = a_full_q;
        assign d[k+1] = a_data_q;
      end else begin : g_half
        logic full_q, full_d;
        logic [DataWidth-1:0] data_q, data_d;
        always_comb begin
          full_d = full_q ? ~r[k+1] : v[k];
          data_d = full_q ? data_q : d[k];
        end
        always_ff @(posedge i_clk) begin
          full_q <= i_rst ? 1'b0 : full_d;
          data_q <= data_d;
        end
        assign r[k] = ~full_q;
        assign v[k+1] = full_q;
        assign d[k+1] = data_q;
      end
    end
    assign o_s_ready[c] = r[0] & ~i_isolate & ~i_rst;
    assign o_m_valid[c] = v[NumCuts] & ~i_rst;
    assign o_m_data[c*DataWidth +: DataWidth] = d[NumCuts];
    assign o_occupancy[c*OccWidth +: OccWidth] = i_rst ? '0 : occ_q;
    assign empty[c] = occ_q == '0;
    always_comb occ_d = occ_q + OccWidth'(o_s_ready[c] & i_s_valid[c]) - OccWidth'(o_m_valid[c] & i_m_ready[c]);
    always_ff @(posedge i_clk) occ_q <= i_rst ? '0 : occ_d;
    if (NumCuts > 0) begin : g_chk
      assert property (@(posedge i_clk) disable iff (i_rst)
        o_m_valid[c] && !i_m_ready[c] |=> o_m_valid[c] && $stable(o_m_data[c*DataWidth +: DataWidth]));
      assert property (@(posedge i_clk) disable iff (i_rst)
        i_s_valid[c] && !o_s_ready[c] |=> i_s_valid[c] && $stable(i_s_data[c*DataWidth +: DataWidth]));
    end
  end
  always_comb isolated_d = i_isolate & (&empty);
  always_ff @(posedge i_clk) isolated_q <= i_rst ? 1'b0 : isolated_d;
  assign o_isolated = isolated_q & ~i_rst;
  assert property (@(posedge i_clk) NumCuts <= 8);
  assert property (@(posedge i_clk) disable iff (i_rst) o_isolated |-> o_occupancy == '0);
endmodule

// File: tb/tb_axe_multicut_bundle.sv
// tb_axe_multicut_bundle: directed and table-driven checks of full, half and pass-through cuts
module tb_axe_multicut_bundle;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int checks = 0;
  int failures = 0;
  logic rst_f, iso_f, isd_f;
  logic [79:0] sd_f, md_f;
  logic [4:0] sv_f, sr_f, mv_f, mr_f;
  logic [14:0] occ_f;
  logic rst_h, iso_h, isd_h;
  logic [15:0] sd_h, md_h;
  logic [0:0] sv_h, sr_h, mv_h, mr_h;
  logic [2:0] occ_h;
  logic rst_p, iso_p, isd_p;
  logic [15:0] sd_p, md_p;
  logic [1:0] sv_p, sr_p, mv_p, mr_p, occ_p;
  axe_multicut_bundle #(.NumChannels(5), .DataWidth(16), .NumCuts(2), .CutMode(0)) u_full (
    .i_clk(clk), .i_rst(rst_f), .i_isolate(iso_f), .o_isolated(isd_f),
    .i_s_data(sd_f), .i_s_valid(sv_f), .o_s_ready(sr_f),
    .o_m_data(md_f), .o_m_valid(mv_f), .i_m_ready(mr_f), .o_occupancy(occ_f));
  axe_multicut_bundle #(.NumChannels(1), .DataWidth(16), .NumCuts(3), .CutMode(1)) u_half (
    .i_clk(clk), .i_rst(rst_h), .i_isolate(iso_h), .o_isolated(isd_h),
    .i_s_data(sd_h), .i_s_valid(sv_h), .o_s_ready(sr_h),
    .o_m_data(md_h), .o_m_valid(mv_h), .i_m_ready(mr_h), .o_occupancy(occ_h));
  axe_multicut_bundle #(.NumChannels(2), .DataWidth(8), .NumCuts(0), .CutMode(0)) u_pass (
    .i_clk(clk), .i_rst(rst_p), .i_isolate(iso_p), .o_isolated(isd_p),
    .i_s_data(sd_p), .i_s_valid(sv_p), .o_s_ready(sr_p),
    .o_m_data(md_p), .o_m_valid(mv_p), .i_m_ready(mr_p), .o_occupancy(occ_p));
  typedef struct {
    logic iso;
    logic [1:0] v;
    logic [1:0] r;
    logic [15:0] d;
    logic [1:0] ev;
    logic [1:0] er;
    logic ei;
  } vec_t;
  vec_t tbl [10];
  logic iso_ev [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic [15:0] iso_ed [3] = '{16'hA0, 16'hA1, 16'hA2};
  logic iso_ei [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic run_stream(input int lo, input int hi);
    int sent [5];
    int rcvd [5];
    int first0, last0, ch0_stall;
    first0 = -1;
    last0 = -1;
    ch0_stall = 0;
    for (int c = 0; c < 5; c++) begin
      sent[c] = 0;
      rcvd[c] = 0;
    end
    for (int cyc = 0; cyc < 140; cyc++) begin
      for (int c = 0; c < 5; c++) begin
        sv_f[c] = sent[c] < 100;
        sd_f[c*16 +: 16] = 16'(c * 256 + sent[c]);
        mr_f[c] = !(c == 1 && cyc >= lo && cyc < hi);
      end
      @(negedge clk);
      if (cyc == 50) check("stream_occ0", 64'(occ_f[2:0]), 64'd2);
      if (hi > 0 && cyc == hi - 1) begin
        check("stall_occ1", 64'(occ_f[5:3]), 64'd4);
        check("stall_s_ready1", 64'(sr_f[1]), 64'd0);
        check("stall_m_valid1", 64'(mv_f[1]), 64'd1);
      end
      for (int c = 0; c < 5; c++) begin
        if (sv_f[c] && sr_f[c]) sent[c]++;
        if (mv_f[c] && mr_f[c]) begin
          check($sformatf("stream_data%0d", c), 64'(md_f[c*16 +: 16]), 64'(c * 256 + rcvd[c]));
          if (c == 0) begin
            if (first0 < 0) first0 = cyc;
            last0 = cyc;
            if (cyc >= lo && cyc < hi) ch0_stall++;
          end
          rcvd[c]++;
        end
      end
      step();
    end
    sv_f = '0;
    check("stream_first_out", 64'(first0), 64'd2);
    check("stream_last_out", 64'(last0), 64'd101);
    for (int c = 0; c < 5; c++) check($sformatf("stream_count%0d", c), 64'(rcvd[c]), 64'd100);
    if (hi > lo) check("stall_other_flow", 64'(ch0_stall), 64'(hi - lo));
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    int sent_h, rcvd_h, peak;
    logic seen, prev_iso;
    logic [1:0] ev;
    tbl[0] = '{1'b0, 2'b11, 2'b11, 16'hA55A, 2'b11, 2'b11, 1'b0};
    tbl[1] = '{1'b0, 2'b01, 2'b10, 16'h1234, 2'b01, 2'b10, 1'b0};
    tbl[2] = '{1'b0, 2'b10, 2'b01, 16'hFF00, 2'b10, 2'b01, 1'b0};
    tbl[3] = '{1'b1, 2'b11, 2'b11, 16'h0F0F, 2'b00, 2'b00, 1'b0};
    tbl[4] = '{1'b1, 2'b01, 2'b11, 16'h3C3C, 2'b00, 2'b00, 1'b1};
    tbl[5] = '{1'b0, 2'b11, 2'b01, 16'hC3C3, 2'b11, 2'b01, 1'b1};
    tbl[6] = '{1'b0, 2'b00, 2'b11, 16'h7E7E, 2'b00, 2'b11, 1'b0};
    tbl[7] = '{1'b1, 2'b10, 2'b00, 16'h8181, 2'b00, 2'b00, 1'b0};
    tbl[8] = '{1'b0, 2'b11, 2'b00, 16'h9999, 2'b11, 2'b00, 1'b1};
    tbl[9] = '{1'b0, 2'b01, 2'b11, 16'h0001, 2'b01, 2'b11, 1'b0};
    rst_f = 1'b1; iso_f = 1'b0; sd_f = '0; sv_f = '0; mr_f = '0;
    rst_h = 1'b1; iso_h = 1'b0; sd_h = '0; sv_h = '0; mr_h = '0;
    rst_p = 1'b1; iso_p = 1'b0; sd_p = 16'h5AA5; sv_p = 2'b11; mr_p = 2'b11;
    step();
    step();
    @(negedge clk);
    check("rst_s_ready_f", 64'(sr_f), 64'd0);
    check("rst_m_valid_f", 64'(mv_f), 64'd0);
    check("rst_occ_f", 64'(occ_f), 64'd0);
    check("rst_isolated_f", 64'(isd_f), 64'd0);
    check("rst_s_ready_h", 64'(sr_h), 64'd0);
    check("rst_m_valid_p", 64'(mv_p), 64'd0);
    check("rst_s_ready_p", 64'(sr_p), 64'd0);
    step();
    rst_f = 1'b0; rst_h = 1'b0; rst_p = 1'b0;
    @(negedge clk);
    check("post_rst_s_ready_f", 64'(sr_f), 64'h1f);
    check("post_rst_s_ready_h", 64'(sr_h), 64'd1);
    check("post_rst_s_ready_p", 64'(sr_p), 64'd3);
    step();
    run_stream(0, 0);
    run_stream(5, 15);
    mr_f = 5'b11110;
    for (int i = 0; i < 3; i++) begin
      sv_f[0] = 1'b1;
      sd_f[15:0] = 16'(16'hA0 + i);
      @(negedge clk);
      check("iso_fill_ready", 64'(sr_f[0]), 64'd1);
      step();
    end
    sv_f[0] = 1'b0;
    @(negedge clk);
    check("iso_fill_occ", 64'(occ_f[2:0]), 64'd3);
    step();
    iso_f = 1'b1; mr_f[0] = 1'b1; sv_f[0] = 1'b1; sd_f[15:0] = 16'hB0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("iso_s_ready", 64'(sr_f), 64'd0);
      check("iso_m_valid0", 64'(mv_f[0]), 64'(iso_ev[i]));
      if (i < 3) check("iso_data0", 64'(md_f[15:0]), 64'(iso_ed[i]));
      check("iso_flag", 64'(isd_f), 64'(iso_ei[i]));
      step();
    end
    iso_f = 1'b0;
    @(negedge clk);
    check("resume_ready", 64'(sr_f[0]), 64'd1);
    check("iso_hold", 64'(isd_f), 64'd1);
    step();
    sv_f[0] = 1'b0;
    @(negedge clk);
    check("iso_fall", 64'(isd_f), 64'd0);
    check("resume_occ", 64'(occ_f[2:0]), 64'd1);
    step();
    @(negedge clk);
    check("resume_m_valid", 64'(mv_f[0]), 64'd1);
    check("resume_data", 64'(md_f[15:0]), 64'hB0);
    step();
    sv_f[0] = 1'b1; sd_f[15:0] = 16'hC0;
    @(negedge clk);
    step();
    sd_f[15:0] = 16'hC1;
    @(negedge clk);
    step();
    sv_f[0] = 1'b0; rst_f = 1'b1;
    @(negedge clk);
    check("midrst_m_valid", 64'(mv_f), 64'd0);
    check("midrst_occ", 64'(occ_f), 64'd0);
    check("midrst_s_ready", 64'(sr_f), 64'd0);
    check("midrst_isolated", 64'(isd_f), 64'd0);
    step();
    rst_f = 1'b0;
    @(negedge clk);
    check("midrst_post_ready", 64'(sr_f), 64'h1f);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      @(negedge clk);
      seen = seen | (|mv_f);
    end
    check("midrst_no_stale", 64'(seen), 64'd0);
    check("midrst_occ_after", 64'(occ_f), 64'd0);
    step();
    sent_h = 0; rcvd_h = 0; peak = 0;
    sv_h = 1'b1;
    for (int cyc = 0; cyc < 108; cyc++) begin
      mr_h = 1'(cyc >= 8);
      sd_h = 16'(sent_h);
      @(negedge clk);
      if (int'(occ_h) > peak) peak = int'(occ_h);
      if (cyc == 7) begin
        check("half_full_occ", 64'(occ_h), 64'd3);
        check("half_full_ready", 64'(sr_h), 64'd0);
        check("half_full_data", 64'(md_h), 64'd0);
      end
      if (sv_h && sr_h) sent_h++;
      if (mv_h && mr_h) begin
        check("half_data", 64'(md_h), 64'(rcvd_h));
        rcvd_h++;
      end
      step();
    end
    sv_h = 1'b0;
    check("half_beats_per_100", 64'(rcvd_h), 64'd50);
    check("half_peak_occ", 64'(peak), 64'd3);
    for (int i = 0; i < 10; i++) begin
      iso_p = tbl[i].iso; sv_p = tbl[i].v; mr_p = tbl[i].r; sd_p = tbl[i].d;
      @(negedge clk);
      check($sformatf("pass_m_valid%0d", i), 64'(mv_p), 64'(tbl[i].ev));
      check($sformatf("pass_s_ready%0d", i), 64'(sr_p), 64'(tbl[i].er));
      check($sformatf("pass_data%0d", i), 64'(md_p), 64'(tbl[i].d));
      check($sformatf("pass_isolated%0d", i), 64'(isd_p), 64'(tbl[i].ei));
      step();
    end
    prev_iso = tbl[9].iso;
    for (int i = 0; i < 20; i++) begin
      iso_p = 1'($urandom_range(0, 3) == 0);
      sv_p = 2'($urandom);
      mr_p = 2'($urandom);
      sd_p = 16'($urandom);
      ev = sv_p & {2{~iso_p}};
      @(negedge clk);
      check("rand_m_valid", 64'(mv_p), 64'(ev));
      check("rand_s_ready", 64'(sr_p), 64'(mr_p & {2{~iso_p}}));
      check("rand_data", 64'(md_p), 64'(sd_p));
      check("rand_isolated", 64'(isd_p), 64'(prev_iso));
      check("rand_occ", 64'(occ_p), 64'd0);
      prev_iso = iso_p;
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axe_multicut_bundle.md
Name: axe_multicut_bundle

Overview:
- Parametrised multi-channel valid/ready pipeline cut. Carries NumChannels independent streams, e.g. the five AXI channels of one port, each through NumCuts register stages.
- Selectable stage mode: full-throughput spill or half-throughput single-entry.
- Per-channel occupancy reporting and an isolate/drain handshake.
- Sits on long inter-block AXI/NoC routes and at power/reset-domain boundaries that need quiescing before isolation.

Parameters:
- NumChannels, 5, number of independent valid/ready channels (>=1).
- DataWidth, 64, payload width per channel (>=1); unused MSBs of narrower channels are tied off by the parent.
- NumCuts, 1, register stages per channel (0..8); 0 is a combinational pass-through.
- CutMode, 0, stage type: 0 = full (2-entry spill, 100% throughput); 1 = half (1-entry, max 50% throughput, fewer flops).
- OccWidth, $clog2(2*NumCuts+1), derived, width of each occupancy field.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_isolate  in  1  isolation request.
- o_isolated  out  1  all channels drained while isolating.
- i_s_data  in  NumChannels*DataWidth  subordinate-side payload; channel c at [c*DataWidth +: DataWidth].
- i_s_valid  in  NumChannels  subordinate-side valid.
- o_s_ready  out  NumChannels  subordinate-side ready.
- o_m_data  out  NumChannels*DataWidth  manager-side payload.
- o_m_valid  out  NumChannels  manager-side valid.
- i_m_ready  in  NumChannels  manager-side ready.
- o_occupancy  out  NumChannels*OccWidth  beats held per channel.

Behaviour:
- Reset: one clock, one synchronous active-high reset (i_clk / i_rst).
  - While i_rst=1: o_s_ready=0, o_m_valid=0, o_occupancy=0, o_isolated=0, all stages emptied. o_m_data is don't-care.
  - Reset asserted mid-operation discards in-flight beats; no beat appears after reset.
  - First cycle after reset release: o_s_ready=1 unless i_isolate=1.
- Channel independence: channels never interact; stall on one never affects another.
- Handshakes: transfer when valid&&ready.
  - o_m_valid, once high, holds with stable o_m_data until i_m_ready.
  - o_m_valid never depends combinationally on i_m_ready; o_s_ready never depends combinationally on i_s_valid.
- Full mode (CutMode=0): each stage is a 2-entry spill register.
  - Valid, data and ready paths are all registered.
  - Capacity 2*NumCuts; sustained 1 beat/cycle.
  - Stage ready = not full; push and pop in the same cycle on a non-empty stage keep the occupancy constant.
- Half mode (CutMode=1): each stage holds 1 entry.
  - A stage accepts only when empty; a pop and a push cannot occur in the same cycle at one stage.
  - Capacity NumCuts; sustained throughput 1 beat per 2 cycles.
- Latency: a beat accepted at cycle t is visible on o_m_valid at t+NumCuts (empty pipe, i_m_ready=1). NumCuts=0 is zero-latency combinational.
- Ordering: strict FIFO per channel; no beat lost or duplicated under any ready pattern.
- Occupancy: o_occupancy[c] is registered and equals beats accepted minus beats emitted on channel c.
  - It reflects handshakes of the previous cycle.
  - It saturates by construction at capacity and never wraps.
- Isolation:
  - i_isolate=1 forces o_s_ready=0 on all channels combinationally; the manager side keeps draining normally.
  - o_isolated is registered: it rises the cycle after (i_isolate && all occupancy==0) and falls the cycle after i_isolate drops.
  - Subordinate acceptance resumes in the same cycle i_isolate drops.
  - NumCuts=0: i_isolate also forces o_m_valid=0, and o_isolated follows i_isolate with 1-cycle delay.
- Assertions: NumCuts<=8; stable payload while valid&&!ready on both sides; o_isolated implies zero occupancy.

Test Plan:
- Streaming: NumChannels=5, NumCuts=2, CutMode=0; stream 100 incrementing beats per channel with constant ready -> first out at cycle t+2, 1 beat/cycle, all values in order.
- Backpressure: i_m_ready=0 for 10 cycles on channel 1 only (full mode, NumCuts=2) -> channel 1 holds 4 beats, o_occupancy[1]=4 and o_s_ready[1]=0; other channels keep streaming. On release, channel 1 drains in order.
- Half mode: CutMode=1, NumCuts=3, continuous valid and ready -> exactly 50 beats out per 100 cycles; peak occupancy 3.
- Isolation drain: channel 0 holds 3 beats; assert i_isolate with i_m_ready=1 -> o_s_ready=0 immediately, o_isolated=1 exactly one cycle after the last beat leaves. Deassert -> o_isolated=0 next cycle, accepting again.
- Mid-operation reset: assert i_rst for 1 cycle with 2 beats in flight -> o_m_valid=0 and occupancy=0 during reset; no stale beat afterwards; o_s_ready=1 on the first post-reset cycle.
- Pass-through: NumCuts=0 with random valid/ready -> outputs equal inputs combinationally. i_isolate=1 gates both sides; o_isolated asserts one cycle later.
